// File: rtl/bidir_buf_pkg.sv
// Shared constants and state encoding for the bidirectional-buffer peer endpoint.
package bidir_buf_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int CNT_W      = 4;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_TX      = 2'd1;
    localparam state_t S_RX_WAIT = 2'd2;
    localparam state_t S_TURN    = 2'd3;

    function automatic logic [CNT_W-1:0] to_cnt(input int value);
        return value[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/bidir_buf_peer_if.sv
// Local-side handshake plus buffer direction controls of the peer endpoint.
interface bidir_buf_peer_if
    import bidir_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_req;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              send_data;
    logic              recv_data;

    // master: the local producer/consumer; slave: the peer endpoint itself.
    modport master (
        output tx_valid, tx_data, rx_req,
        input  tx_ready, rx_valid, rx_data, send_data, recv_data
    );

    modport slave (
        input  tx_valid, tx_data, rx_req,
        output tx_ready, rx_valid, rx_data, send_data, recv_data
    );

endinterface

// File: rtl/bidir_turn_timer.sv
// Loadable down-counter; o_done marks the last cycle of a loaded interval.
module bidir_turn_timer
    import bidir_buf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/bidir_buf_peer.sv
// Half-duplex peer endpoint: arbitrates bus direction, drives buffer controls, moves one word per transaction.
module bidir_buf_peer
    import bidir_buf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RX_LAT   = 2,
    parameter int TURN_CYC = 1
)(
    input  logic                  clk,
    input  logic                  rst_n,
    bidir_buf_peer_if.slave       bif,
    inout  wire      [DATA_W-1:0] data_bus
);

    state_t            r_state;
    logic              r_rx_pend;
    logic              r_last_rx;
    logic              r_bus_oe;
    logic              r_rx_valid;
    logic [DATA_W-1:0] r_tx_word;
    logic [DATA_W-1:0] r_rx_data;

    logic              w_idle;
    logic              w_grant_tx;
    logic              w_grant_rx;
    logic              w_timer_load;
    logic              w_timer_done;
    logic [CNT_W-1:0]  w_timer_value;

    assign w_idle = (r_state == S_IDLE);

    // On a tie the direction not used last time wins; last_rx resets high so TX takes the first tie.
    assign w_grant_tx = w_idle && bif.tx_valid && (!r_rx_pend || r_last_rx);
    assign w_grant_rx = w_idle && r_rx_pend && (!bif.tx_valid || !r_last_rx);

    assign w_timer_load  = w_grant_rx || (r_state == S_TX) ||
                           ((r_state == S_RX_WAIT) && w_timer_done);
    assign w_timer_value = w_grant_rx ? to_cnt(RX_LAT) : to_cnt(TURN_CYC);

    bidir_turn_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_timer_load),
        .i_value (w_timer_value),
        .o_done  (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rx_pend  <= 1'b0;
            r_last_rx  <= 1'b1;
            r_bus_oe   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_word  <= '0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            // A request landing on the grant cycle is absorbed by that grant.
            r_rx_pend  <= w_grant_rx ? 1'b0 : (r_rx_pend || bif.rx_req);
            case (r_state)
                S_IDLE: begin
                    if (w_grant_tx) begin
                        r_tx_word <= bif.tx_data;
                        r_bus_oe  <= 1'b1;
                        r_last_rx <= 1'b0;
                        r_state   <= S_TX;
                    end else if (w_grant_rx) begin
                        r_last_rx <= 1'b1;
                        r_state   <= S_RX_WAIT;
                    end
                end
                S_TX: begin
                    r_bus_oe <= 1'b0;
                    r_state  <= S_TURN;
                end
                S_RX_WAIT: begin
                    if (w_timer_done) begin
                        r_rx_data  <= data_bus;
                        r_rx_valid <= 1'b1;
                        r_state    <= S_TURN;
                    end
                end
                default: begin
                    if (w_timer_done) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Gated by rst_n so a waiting producer never sees ready while reset is held.
    assign bif.tx_ready  = rst_n && w_grant_tx;
    assign bif.send_data = (r_state == S_RX_WAIT);
    assign bif.recv_data = (r_state == S_TX);
    assign bif.rx_valid  = r_rx_valid;
    assign bif.rx_data   = r_rx_data;

    assign data_bus = r_bus_oe ? r_tx_word : {DATA_W{1'bz}};

    a_no_dual_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bif.send_data && bif.recv_data));
    a_no_bus_fight: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_bus_oe && bif.send_data));
    a_oe_only_tx:   assert property (@(posedge clk) disable iff (!rst_n)
        r_bus_oe |-> (r_state == S_TX));

endmodule

// File: tb/tb_bidir_buf_peer.sv
// Directed bench for bidir_buf_peer with scoreboards for TX bus words and RX captures.
module tb_bidir_buf_peer;
    import bidir_buf_pkg::*;

    localparam int W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bidir_buf_peer_if #(.DATA_W(W)) bif  ();
    bidir_buf_peer_if #(.DATA_W(W)) bif2 ();

    wire  [W-1:0] bus;
    wire  [W-1:0] bus2;
    logic [W-1:0] buf_word  = 3'b011;
    logic [W-1:0] buf_word2 = 3'b110;

    // Buffer-side model: drives the bus toward the peer whenever send_data is high.
    assign bus  = bif.send_data  ? buf_word  : {W{1'bz}};
    assign bus2 = bif2.send_data ? buf_word2 : {W{1'bz}};

    bidir_buf_peer #(.DATA_W(W), .RX_LAT(2), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .bif(bif), .data_bus(bus));

    bidir_buf_peer #(.DATA_W(W), .RX_LAT(1), .TURN_CYC(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .bif(bif2), .data_bus(bus2));

    logic [W-1:0] exp_tx_q[$];
    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] exp_tx2_q[$];
    logic [W-1:0] exp_rx2_q[$];
    bit           order_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit order_en   = 0;
    bit prev_send  = 0;
    bit prev_recv  = 0;
    bit prev_send2 = 0;
    int rx_starts  = 0;
    int rx_valids  = 0;
    int hs2_cnt    = 0;
    int hs2_last   = 0;
    int send2_cyc  = 0;
    int rx_valids2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        cyc++;
        check("inv_send_recv", bif.send_data && bif.recv_data, 0);
        check("inv_send_recv2", bif2.send_data && bif2.recv_data, 0);

        if (bif.tx_valid && bif.tx_ready) exp_tx_q.push_back(bif.tx_data);
        if (bif.recv_data) begin
            if (exp_tx_q.size() == 0) check("tx_unexpected", 1, 0);
            else begin e = exp_tx_q.pop_front(); check("tx_bus", bus, e); end
        end
        if (bif.send_data) check("no_peer_drive", dut.r_bus_oe, 0);
        if (bif.send_data && !prev_send) begin
            exp_rx_q.push_back(buf_word);
            rx_starts++;
        end
        if (order_en && ((bif.send_data && !prev_send) || (bif.recv_data && !prev_recv))) begin
            if (order_q.size() != 0) check("grant_order", bif.send_data, order_q.pop_front());
            check("turn_gap", prev_send || prev_recv, 0);
        end
        if (bif.rx_valid) begin
            rx_valids++;
            if (exp_rx_q.size() == 0) check("rx_unexpected", 1, 0);
            else begin e = exp_rx_q.pop_front(); check("rx_data", bif.rx_data, e); end
        end
        prev_send = bif.send_data;
        prev_recv = bif.recv_data;

        if (bif2.tx_valid && bif2.tx_ready) begin
            exp_tx2_q.push_back(bif2.tx_data);
            if (hs2_cnt > 0) check("tx2_interval", cyc - hs2_last, 5);
            hs2_last = cyc;
            hs2_cnt++;
        end
        if (bif2.recv_data) begin
            if (exp_tx2_q.size() == 0) check("tx2_unexpected", 1, 0);
            else begin e = exp_tx2_q.pop_front(); check("tx2_bus", bus2, e); end
        end
        if (bif2.send_data) begin
            send2_cyc++;
            check("no_peer_drive2", dut2.r_bus_oe, 0);
        end
        if (bif2.send_data && !prev_send2) exp_rx2_q.push_back(buf_word2);
        if (bif2.rx_valid) begin
            rx_valids2++;
            if (exp_rx2_q.size() == 0) check("rx2_unexpected", 1, 0);
            else begin e = exp_rx2_q.pop_front(); check("rx2_data", bif2.rx_data, e); end
        end
        prev_send2 = bif2.send_data;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.tx_valid  = 1'b1;  // held during reset: tx_ready must still read 0
        bif.tx_data   = 3'b101;
        bif.rx_req    = 1'b0;
        bif2.tx_valid = 1'b0;
        bif2.tx_data  = '0;
        bif2.rx_req   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_tx_ready", bif.tx_ready, 0);
        check("rst_send", bif.send_data, 0);
        check("rst_recv", bif.recv_data, 0);
        check("rst_rx_valid", bif.rx_valid, 0);
        check("rst_rx_data", bif.rx_data, 0);
        check("rst_bus_oe", dut.r_bus_oe, 0);
        check("rst_last_rx", dut.r_last_rx, 1);
        rst_n = 1'b1;

        // Single TX, then a second word to time tx_ready's return
        sample(); check("t1_ready_first", bif.tx_ready, 1); advance();
        bif.tx_data = 3'b010;
        sample();
        check("t1_recv", bif.recv_data, 1);
        check("t1_bus", bus, 3'b101);
        check("t1_ready_tx", bif.tx_ready, 0);
        advance();
        sample();
        check("t1_turn_oe", dut.r_bus_oe, 0);
        check("t1_turn_recv", bif.recv_data, 0);
        check("t1_ready_turn", bif.tx_ready, 0);
        advance();
        sample(); check("t1_ready_back", bif.tx_ready, 1); advance();
        bif.tx_valid = 1'b0;
        repeat (3) tick();
        check("t1_tx_drained", exp_tx_q.size(), 0);

        // Single RX from a one-cycle request
        bif.rx_req = 1'b1;
        sample(); check("t2_send_a0", bif.send_data, 0); advance();
        bif.rx_req = 1'b0;
        sample(); check("t2_send_a1", bif.send_data, 0); advance();
        sample(); check("t2_send_a2", bif.send_data, 1); advance();
        sample(); check("t2_send_a3", bif.send_data, 1); advance();
        sample();
        check("t2_send_a4", bif.send_data, 0);
        check("t2_rx_valid", bif.rx_valid, 1);
        check("t2_rx_data", bif.rx_data, 3'b011);
        advance();
        sample();
        check("t2_rx_valid_off", bif.rx_valid, 0);
        check("t2_rx_data_hold", bif.rx_data, 3'b011);
        advance();

        // Both directions requesting: grants alternate TX, RX, TX, RX
        order_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        order_en = 1'b1;
        bif.tx_valid = 1'b1;
        bif.rx_req   = 1'b1;
        for (int i = 0; i < 40 && order_q.size() != 0; i++) begin
            bif.tx_data = W'(i);
            tick();
        end
        check("t3_order_done", order_q.size(), 0);
        order_en     = 1'b0;
        bif.tx_valid = 1'b0;
        bif.rx_req   = 1'b0;
        repeat (12) tick();
        check("t3_tx_drained", exp_tx_q.size(), 0);
        check("t3_rx_drained", exp_rx_q.size(), 0);

        // Repeated requests during one TX collapse into a single RX
        rx_starts = 0;
        rx_valids = 0;
        bif.tx_valid = 1'b1;
        bif.tx_data  = 3'b111;
        tick();
        bif.tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bif.rx_req = 1'b1;
            tick();
        end
        bif.rx_req = 1'b0;
        repeat (15) tick();
        check("t4_rx_starts", rx_starts, 1);
        check("t4_rx_valids", rx_valids, 1);
        check("t4_tx_drained", exp_tx_q.size(), 0);

        // Reset asserted in RX_WAIT
        rx_starts = 0;
        rx_valids = 0;
        bif.rx_req = 1'b1;
        tick();
        bif.rx_req = 1'b0;
        tick();
        sample(); check("t5_send_before", bif.send_data, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_send_async", bif.send_data, 0);
        check("t5_oe_async", dut.r_bus_oe, 0);
        exp_rx_q.delete();
        advance();
        for (int i = 0; i < 2; i++) begin
            sample(); check("t5_rx_valid_rst", bif.rx_valid, 0); advance();
        end
        rst_n = 1'b1;
        sample();
        check("t5_state_idle", dut.r_state, S_IDLE);
        check("t5_send", bif.send_data, 0);
        check("t5_recv", bif.recv_data, 0);
        check("t5_tx_ready", bif.tx_ready, 0);
        check("t5_rx_valid", bif.rx_valid, 0);
        check("t5_rx_data", bif.rx_data, 0);
        check("t5_rx_pend", dut.r_rx_pend, 0);
        check("t5_last_rx", dut.r_last_rx, 1);
        advance();
        repeat (6) tick();
        check("t5_no_rx_valid", rx_valids, 0);

        // TURN_CYC=3, RX_LAT=1: back-to-back TX, then a single RX
        hs2_cnt = 0;
        bif2.tx_valid = 1'b1;
        for (int i = 0; i < 40 && hs2_cnt < 5; i++) begin
            bif2.tx_data = W'(i + 1);
            tick();
        end
        check("t6_words", hs2_cnt, 5);
        bif2.tx_valid = 1'b0;
        repeat (6) tick();
        check("t6_tx_drained", exp_tx2_q.size(), 0);
        send2_cyc  = 0;
        rx_valids2 = 0;
        bif2.rx_req = 1'b1;
        tick();
        bif2.rx_req = 1'b0;
        repeat (8) tick();
        check("t6_send_cycles", send2_cyc, 1);
        check("t6_rx_valids", rx_valids2, 1);
        check("t6_rx_drained", exp_rx2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
